data_mem_interface: RTL

//  MIPS MEM-stage data-memory interface, directly upstream of Trunker. Accepts load/store

---
 rtl/dmi_pkg.sv | 77 +++++++
 rtl/dmi_ram.sv | 37 +++
 rtl/data_mem_interface.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory interface.
// Sub-word alignment is centralised here so the store merge and load extract agree.
package dmi_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RMW_RD = 2'b01,
    ST_RMW_WR = 2'b10
  } dmi_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis_s;
    case (size)
      SIZE_BYTE: mis_s = 1'b0;
      SIZE_HALF: mis_s = off[0];
      default:   mis_s = (off != 2'b00);
    endcase
    return mis_s;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask_s;
    case (size)
      SIZE_BYTE: mask_s = 4'b0001 << off;
      SIZE_HALF: mask_s = 4'b0011 << {off[1], 1'b0};
      default:   mask_s = 4'b1111;
    endcase
    return mask_s;
  endfunction

  // Moves right-justified store data up into its byte lane(s).
  function automatic logic [31:0] lane_place(input logic [31:0] wdata, input logic [1:0] size,
                                             input logic [1:0] off);
    logic [31:0] placed_s;
    case (size)
      SIZE_BYTE: placed_s = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
      SIZE_HALF: placed_s = {16'h0000, wdata[15:0]} << {off[1], 4'b0000};
      default:   placed_s = wdata;
    endcase
    return placed_s;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] placed_s;
    logic [3:0]  mask_s;
    logic [31:0] merged_s;
    placed_s = lane_place(wdata, size, off);
    mask_s   = lane_mask(size, off);
    merged_s = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask_s[i]) begin
        merged_s[8*i +: 8] = placed_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged_s;
  endfunction

  // Right-justifies the addressed lane; bits above it are zero, extension is left downstream.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off);
    logic [31:0] data_s;
    case (size)
      SIZE_BYTE: data_s = (word >> {off, 3'b000}) & 32'h0000_00FF;
      SIZE_HALF: data_s = (word >> {off[1], 4'b0000}) & 32'h0000_FFFF;
      default:   data_s = word;
    endcase
    return data_s;
  endfunction

endpackage

// File: rtl/dmi_ram.sv
// Single-port 32-bit synchronous RAM with registered read; the read register holds when re=0.
// DMI_BYTE_ENABLE_EN adds a per-byte write-enable port.
module dmi_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
`ifdef DMI_BYTE_ENABLE_EN
  input  logic [3:0]            be,
`endif
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [2**ADDR_WIDTH];

  // Storage array write and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef DMI_BYTE_ENABLE_EN
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
`else
      mem_r[addr] <= wdata;
`endif
    end
    if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/data_mem_interface.sv
// MEM-stage data-memory interface: store merging, load lane alignment, hand-off to Trunker.
// DMI_BYTE_ENABLE_EN selects single-cycle byte-enabled stores instead of the RMW FSM.
module data_mem_interface #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        I_DMI_clk,
  input  logic        I_DMI_rst_n,
  input  logic        I_DMI_valid,
  input  logic        I_DMI_write,
  input  logic [31:0] I_DMI_addr,
  input  logic [31:0] I_DMI_wdata,
  input  logic [1:0]  I_DMI_size,
  input  logic        I_DMI_sign,
  output logic        O_DMI_stall,
  output logic [31:0] O_DMI_rdata,
  output logic [1:0]  O_DMI_size,
  output logic        O_DMI_sign,
  output logic        O_DMI_rvalid,
  output logic        O_DMI_misaligned
);
  import dmi_pkg::*;

  logic [1:0]            off_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic                  accept_s;
  logic                  mis_s;
  logic                  load_ok_s;
  logic                  store_ok_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [31:0]           ram_wdata_s;
  logic [31:0]           ram_q_s;
  logic [31:0]           aligned_s;
  logic [31:0]           hold_r;
  logic [1:0]            lane_r;
  logic                  unused_addr_s;

  assign off_s         = I_DMI_addr[1:0];
  assign waddr_s       = I_DMI_addr[ADDR_WIDTH+1:2];
  assign unused_addr_s = ^I_DMI_addr[31:ADDR_WIDTH+2];
  assign accept_s      = I_DMI_valid && !O_DMI_stall;
  assign mis_s         = is_misaligned(I_DMI_size, off_s);
  assign load_ok_s     = accept_s && !I_DMI_write && !mis_s;
  assign store_ok_s    = accept_s && I_DMI_write && !mis_s;

`ifdef DMI_BYTE_ENABLE_EN
  logic [3:0] ram_be_s;

  assign O_DMI_stall = 1'b0;

  // Byte-enabled RAM takes every store in the accept cycle
  always_comb begin
    ram_addr_s  = waddr_s;
    ram_we_s    = store_ok_s;
    ram_re_s    = load_ok_s;
    ram_be_s    = lane_mask(I_DMI_size, off_s);
    ram_wdata_s = lane_place(I_DMI_wdata, I_DMI_size, off_s);
  end

  dmi_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (I_DMI_clk),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .be    (ram_be_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_q_s)
  );
`else
  dmi_state_e            state_r;
  logic [ADDR_WIDTH-1:0] rmw_addr_r;
  logic [31:0]           rmw_wdata_r;
  logic [1:0]            rmw_size_r;
  logic [1:0]            rmw_off_r;

  assign O_DMI_stall = (state_r != ST_IDLE);

  // RAM port steering: request port in IDLE, captured store during read-modify-write
  always_comb begin
    ram_addr_s  = waddr_s;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_wdata_s = I_DMI_wdata;
    case (state_r)
      ST_IDLE: begin
        ram_we_s = store_ok_s && I_DMI_size[1];
        ram_re_s = load_ok_s;
      end
      ST_RMW_RD: begin
        ram_addr_s = rmw_addr_r;
        ram_re_s   = 1'b1;
      end
      ST_RMW_WR: begin
        ram_addr_s  = rmw_addr_r;
        ram_we_s    = 1'b1;
        ram_wdata_s = lane_merge(ram_q_s, rmw_wdata_r, rmw_size_r, rmw_off_r);
      end
      default: begin
        ram_addr_s = waddr_s;
      end
    endcase
  end

  // Sub-word store FSM; reset returns to IDLE so an in-flight merge never writes
  always_ff @(posedge I_DMI_clk or negedge I_DMI_rst_n) begin
    if (!I_DMI_rst_n) begin
      state_r     <= ST_IDLE;
      rmw_addr_r  <= '0;
      rmw_wdata_r <= 32'h0000_0000;
      rmw_size_r  <= 2'b00;
      rmw_off_r   <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (store_ok_s && !I_DMI_size[1]) begin
            state_r     <= ST_RMW_RD;
            rmw_addr_r  <= waddr_s;
            rmw_wdata_r <= I_DMI_wdata;
            rmw_size_r  <= I_DMI_size;
            rmw_off_r   <= off_s;
          end
        end
        ST_RMW_RD: state_r <= ST_RMW_WR;
        ST_RMW_WR: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  dmi_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (I_DMI_clk),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_q_s)
  );
`endif

  // RMW reads also update the RAM read register, so load data is held separately
  assign aligned_s   = lane_extract(ram_q_s, O_DMI_size, lane_r);
  assign O_DMI_rdata = O_DMI_rvalid ? aligned_s : hold_r;

  // Response pulses and the load attributes handed to Trunker
  always_ff @(posedge I_DMI_clk or negedge I_DMI_rst_n) begin
    if (!I_DMI_rst_n) begin
      O_DMI_rvalid     <= 1'b0;
      O_DMI_misaligned <= 1'b0;
      O_DMI_size       <= 2'b00;
      O_DMI_sign       <= 1'b0;
      lane_r           <= 2'b00;
      hold_r           <= 32'h0000_0000;
    end else begin
      O_DMI_rvalid     <= load_ok_s;
      O_DMI_misaligned <= accept_s && mis_s;
      if (O_DMI_rvalid) begin
        hold_r <= aligned_s;
      end
      if (load_ok_s) begin
        O_DMI_size <= I_DMI_size;
        O_DMI_sign <= I_DMI_sign;
        lane_r     <= off_s;
      end
    end
  end

endmodule
